// File: rtl/dcache_pkg.sv
// Shared types, geometry constants and address-field helpers for the
// direct-mapped write-back L1 data cache.
package dcache_pkg;

  localparam int NUM_LINES  = 32;
  localparam int LINE_BITS  = 256;
  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int IDX_W      = 5;
  localparam int OFS_W      = 5;
  localparam int TAG_W      = ADDR_W - IDX_W - OFS_W;
  localparam int WORD_SEL_W = 3;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MISS       = 3'd1,
    WRITEBACK  = 3'd2,
    ALLOCATE   = 3'd3,
    ALLOC_DONE = 3'd4
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    return addr[OFS_W +: IDX_W];
  endfunction

  function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
    return addr[2 +: WORD_SEL_W];
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side (p1) and memory-side bus of the data cache; the cache controller
// is the master, the pipeline plus off-chip memory form the slave side.
interface dcache_if;
  import dcache_pkg::*;

  logic [ADDR_W-1:0]    p1_addr_i;
  logic [WORD_W-1:0]    p1_data_i;
  logic                 p1_MemRead_i;
  logic                 p1_MemWrite_i;
  logic [WORD_W-1:0]    p1_data_o;
  logic                 p1_stall_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;
  logic [LINE_BITS-1:0] mem_data_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic                 mem_enable_o;
  logic                 mem_write_o;

  modport master (
    input  p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
  );

  modport slave (
    output p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
  );

endinterface

// File: rtl/dcache_sram.sv
// Tag (valid/dirty/tag) and data arrays: one combinational read port and one
// write port doing either a full-line fill or a single-word store.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_BITS-1:0]  rd_line,
  input  logic                  wr_en,
  input  logic                  wr_fill,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [WORD_SEL_W-1:0] wr_word_sel,
  input  logic [WORD_W-1:0]     wr_word,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [LINE_BITS-1:0]  wr_line
);

  logic [NUM_LINES-1:0] valid_r;
  logic [NUM_LINES-1:0] dirty_r;
  logic [TAG_W-1:0]     tag_r  [NUM_LINES];
  logic [LINE_BITS-1:0] data_r [NUM_LINES];

  assign rd_valid = valid_r[rd_idx];
  assign rd_dirty = dirty_r[rd_idx];
  assign rd_tag   = tag_r[rd_idx];
  assign rd_line  = data_r[rd_idx];

  // Line state: a fill makes the line valid and clean, a store marks it dirty.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else if (wr_en) begin
      if (wr_fill) begin
        valid_r[wr_idx] <= 1'b1;
        dirty_r[wr_idx] <= 1'b0;
      end else begin
        dirty_r[wr_idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; validity alone qualifies them.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      if (wr_fill) begin
        tag_r[wr_idx]  <= wr_tag;
        data_r[wr_idx] <= wr_line;
      end else begin
        data_r[wr_idx][{wr_word_sel, 5'b00000} +: WORD_W] <= wr_word;
      end
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back / write-allocate L1 data cache controller:
// hit/miss detection, miss FSM and memory line transfers.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  dcache_if.master bus
);

  state_e                state_r;
  state_e                next_state_s;
  logic [TAG_W-1:0]      tag_s;
  logic [TAG_W-1:0]      rd_tag_s;
  logic [IDX_W-1:0]      idx_s;
  logic [WORD_SEL_W-1:0] word_s;
  logic [LINE_BITS-1:0]  rd_line_s;
  logic [WORD_W-1:0]     rd_word_s;
  logic [WORD_W-1:0]     data_s;
  logic                  rd_valid_s;
  logic                  rd_dirty_s;
  logic                  req_s;
  logic                  wr_req_s;
  logic                  hit_s;
  logic                  wr_en_s;
  logic                  wr_fill_s;
  logic                  stall_s;

  assign tag_s     = addr_tag(bus.p1_addr_i);
  assign idx_s     = addr_idx(bus.p1_addr_i);
  assign word_s    = addr_word(bus.p1_addr_i);
  assign req_s     = bus.p1_MemRead_i | bus.p1_MemWrite_i;
  // A request with both bits set is handled as a store.
  assign wr_req_s  = bus.p1_MemWrite_i;
  assign hit_s     = rd_valid_s & (rd_tag_s == tag_s);
  assign rd_word_s = rd_line_s[{word_s, 5'b00000} +: WORD_W];

  // Reset forces the CPU-facing outputs low without waiting for a clock.
  assign bus.p1_stall_o = stall_s & rst_i;
  assign bus.p1_data_o  = rst_i ? data_s : 32'h0000_0000;

  dcache_sram u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_idx      (idx_s),
    .rd_valid    (rd_valid_s),
    .rd_dirty    (rd_dirty_s),
    .rd_tag      (rd_tag_s),
    .rd_line     (rd_line_s),
    .wr_en       (wr_en_s),
    .wr_fill     (wr_fill_s),
    .wr_idx      (idx_s),
    .wr_word_sel (word_s),
    .wr_word     (bus.p1_data_i),
    .wr_tag      (tag_s),
    .wr_line     (bus.mem_data_i)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; the victim is inspected in MISS to pick write-back or fill.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:       if (req_s && !hit_s)           next_state_s = MISS;
                  else                           next_state_s = IDLE;
      MISS:       if (rd_valid_s && rd_dirty_s)  next_state_s = WRITEBACK;
                  else                           next_state_s = ALLOCATE;
      WRITEBACK:  if (bus.mem_ack_i)             next_state_s = ALLOCATE;
                  else                           next_state_s = WRITEBACK;
      ALLOCATE:   if (bus.mem_ack_i)             next_state_s = ALLOC_DONE;
                  else                           next_state_s = ALLOCATE;
      ALLOC_DONE: next_state_s = IDLE;
      default:    next_state_s = IDLE;
    endcase
  end

  // Output decode; memory strobes depend on the state register only.
  always_comb begin
    stall_s          = 1'b0;
    data_s           = 32'h0000_0000;
    wr_en_s          = 1'b0;
    wr_fill_s        = 1'b0;
    bus.mem_enable_o = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.mem_addr_o   = 32'h0000_0000;
    bus.mem_data_o   = '0;
    case (state_r)
      IDLE: begin
        if (req_s && hit_s) begin
          if (wr_req_s) begin
            wr_en_s = 1'b1;
          end else begin
            data_s = rd_word_s;
          end
        end else if (req_s) begin
          stall_s = 1'b1;
        end else begin
          stall_s = 1'b0;
        end
      end
      MISS:       stall_s = 1'b1;
      WRITEBACK: begin
        stall_s          = 1'b1;
        bus.mem_enable_o = 1'b1;
        bus.mem_write_o  = 1'b1;
        bus.mem_addr_o   = line_addr(rd_tag_s, idx_s);
        bus.mem_data_o   = rd_line_s;
      end
      ALLOCATE: begin
        stall_s          = 1'b1;
        bus.mem_enable_o = 1'b1;
        bus.mem_addr_o   = line_addr(tag_s, idx_s);
        if (bus.mem_ack_i) begin
          wr_en_s   = 1'b1;
          wr_fill_s = 1'b1;
        end else begin
          wr_en_s   = 1'b0;
        end
      end
      ALLOC_DONE: stall_s = 1'b1;
      default:    stall_s = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench: a slow line memory (ack on the 10th enabled cycle) and
// an array-based reference cache predict stalls, load data and line transfers.
module tb_dcache_controller;
  import dcache_pkg::*;

  localparam int LAT = 10;

  typedef struct packed {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  dcache_if bus ();

  dcache_controller dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  logic [255:0] phys_mem [logic [31:0]];
  logic [255:0] ref_mem  [logic [31:0]];
  logic         ref_valid [32];
  logic         ref_dirty [32];
  logic [21:0]  ref_tag   [32];
  logic [255:0] ref_data  [32];
  txn_t         txq   [$];
  txn_t         exp_q [$];
  int           mcnt = 0;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pattern_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = a + 32'(i * 4);
    return l;
  endfunction

  function automatic logic [255:0] phys_read(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : pattern_line(a);
  endfunction

  function automatic logic [255:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pattern_line(a);
  endfunction

  // Slow memory: acknowledges on the LAT-th consecutive enabled cycle.
  always @(negedge clk_i) begin
    txn_t t;
    if (!rst_i || !bus.mem_enable_o) begin
      mcnt = 0;
      bus.mem_ack_i = 1'b0;
    end else begin
      if (bus.mem_ack_i) mcnt = 0;
      mcnt++;
      if (mcnt == LAT) begin
        t.wr   = bus.mem_write_o;
        t.addr = bus.mem_addr_o;
        if (bus.mem_write_o) begin
          t.data = bus.mem_data_o;
          phys_mem[bus.mem_addr_o] = bus.mem_data_o;
        end else begin
          t.data = phys_read(bus.mem_addr_o);
          bus.mem_data_i = t.data;
        end
        txq.push_back(t);
        bus.mem_ack_i = 1'b1;
      end else begin
        bus.mem_ack_i = 1'b0;
      end
    end
  end

  task automatic run_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic is_wr, input logic both);
    logic [4:0]  idx;
    logic [2:0]  word;
    logic [21:0] tag;
    logic [31:0] exp_rdata;
    int          exp_stall;
    int          stalls;
    logic        done;
    txn_t        e;
    idx  = addr[9:5];
    word = addr[4:2];
    tag  = addr[31:10];
    exp_q.delete();
    txq.delete();
    if (ref_valid[idx] && ref_tag[idx] == tag) begin
      exp_stall = 0;
    end else begin
      exp_stall = LAT + 3;
      if (ref_valid[idx] && ref_dirty[idx]) begin
        e.wr = 1'b1; e.addr = {ref_tag[idx], idx, 5'b00000}; e.data = ref_data[idx];
        exp_q.push_back(e);
        ref_mem[e.addr] = e.data;
        exp_stall = 2 * LAT + 3;
      end
      e.wr = 1'b0; e.addr = {addr[31:5], 5'b00000}; e.data = ref_read(e.addr);
      exp_q.push_back(e);
      ref_data[idx]  = e.data;
      ref_tag[idx]   = tag;
      ref_valid[idx] = 1'b1;
      ref_dirty[idx] = 1'b0;
    end
    exp_rdata = ref_data[idx][{word, 5'b00000} +: 32];
    if (is_wr) begin
      ref_data[idx][{word, 5'b00000} +: 32] = wdata;
      ref_dirty[idx] = 1'b1;
    end

    bus.p1_addr_i     = addr;
    bus.p1_data_i     = wdata;
    bus.p1_MemWrite_i = is_wr;
    bus.p1_MemRead_i  = !is_wr || both;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk_i);
      if (bus.p1_stall_o) stalls++;
      else done = 1'b1;
    end
    check_eq("completes", 256'(done), 256'(1'b1));
    check_eq("stall_cycles", 256'(stalls), 256'(exp_stall));
    check_eq("mem_en_at_done", 256'(bus.mem_enable_o), 256'(1'b0));
    if (!is_wr) check_eq("load_data", 256'(bus.p1_data_o), 256'(exp_rdata));
    @(posedge clk_i);
    #1;
    bus.p1_MemRead_i  = 1'b0;
    bus.p1_MemWrite_i = 1'b0;
    #1;
    check_eq("idle_stall", 256'(bus.p1_stall_o), 256'(1'b0));
    check_eq("idle_data", 256'(bus.p1_data_o), 256'(32'h0));
    check_eq("txn_count", 256'(txq.size()), 256'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
      check_eq("txn_write", 256'(txq[i].wr), 256'(exp_q[i].wr));
      check_eq("txn_addr", 256'(txq[i].addr), 256'(exp_q[i].addr));
      if (exp_q[i].wr) check_eq("wb_line", txq[i].data, exp_q[i].data);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] t;
    logic [31:0] a;
    logic        w;
    logic        found;
    for (int i = 0; i < 32; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
      ref_tag[i]   = 22'h0;
      ref_data[i]  = '0;
    end
    bus.p1_addr_i     = 32'h0;
    bus.p1_data_i     = 32'h0;
    bus.p1_MemRead_i  = 1'b0;
    bus.p1_MemWrite_i = 1'b0;
    bus.mem_data_i    = '0;
    #13;
    check_eq("rst_stall", 256'(bus.p1_stall_o), 256'(1'b0));
    check_eq("rst_mem_en", 256'(bus.mem_enable_o), 256'(1'b0));
    check_eq("rst_mem_wr", 256'(bus.mem_write_o), 256'(1'b0));
    check_eq("rst_data", 256'(bus.p1_data_o), 256'(32'h0));
    #10 rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Directed scenarios: fill, hits, dirty eviction, write miss.
    run_access(32'h0000_0040, 32'h0, 1'b0, 1'b0);
    run_access(32'h0000_0044, 32'h0, 1'b0, 1'b0);
    run_access(32'h0000_0048, 32'hDEAD_BEEF, 1'b1, 1'b0);
    run_access(32'h0000_0048, 32'h0, 1'b0, 1'b0);
    run_access(32'h0000_0440, 32'h0, 1'b0, 1'b0);
    run_access(32'h0000_0080, 32'h1234_5678, 1'b1, 1'b0);
    run_access(32'h0000_0080, 32'h0, 1'b0, 1'b0);
    run_access(32'h0000_0480, 32'h0, 1'b0, 1'b0);

    // Random traffic over a few tags and indices to mix hits and conflicts.
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0:       t = 22'h0;
        1:       t = 22'h1;
        2:       t = 22'h2;
        default: t = 22'h3F_FFFF;
      endcase
      a = {t, 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      w = 1'($urandom_range(0, 1));
      run_access(a, $urandom, w, w && ($urandom_range(0, 7) == 0));
    end

    // Reset in the middle of a line fill.
    bus.p1_addr_i    = 32'h0001_80E4;
    bus.p1_MemRead_i = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk_i);
      if (bus.mem_enable_o && !bus.mem_write_o) found = 1'b1;
    end
    check_eq("alloc_seen", 256'(found), 256'(1'b1));
    @(negedge clk_i);
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check_eq("abort_mem_en", 256'(bus.mem_enable_o), 256'(1'b0));
    check_eq("abort_mem_wr", 256'(bus.mem_write_o), 256'(1'b0));
    check_eq("abort_stall", 256'(bus.p1_stall_o), 256'(1'b0));
    check_eq("abort_data", 256'(bus.p1_data_o), 256'(32'h0));
    bus.p1_MemRead_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
    end
    #10 rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    run_access(32'h0000_0044, 32'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the pipeline MEM stage (CPU side, port p1) and a slow off-chip data memory with 256-bit line transfers.
- Replaces the direct Data_Memory connection in the MEM stage.
- Asserts p1_stall_o to freeze the whole pipeline during a miss.

Parameters:
- NUM_LINES, 32, number of cache lines; index width = log2(NUM_LINES) = 5.
- LINE_BITS, 256, line size in bits (32 bytes, 8 words); offset width 5.
- ADDR_W, 32, byte address width; tag width = ADDR_W-10 = 22.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-low
- p1_addr_i  in  32  CPU byte address (ALU result)
- p1_data_i  in  32  CPU store data
- p1_MemRead_i  in  1  load request
- p1_MemWrite_i  in  1  store request
- p1_data_o  out  32  load data
- p1_stall_o  out  1  pipeline stall
- mem_data_i  in  256  line read from memory
- mem_ack_i  in  1  memory transfer complete
- mem_data_o  out  256  line written to memory
- mem_addr_o  out  32  line-aligned memory address (bits[4:0]=0)
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1=write-back, 0=line fill

Behaviour:
- Address split: tag=[31:10], index=[9:5], word=[4:2]; bits[1:0] ignored (word accesses only).
- Tag entry per line: valid, dirty, tag[21:0].
- req = p1_MemRead_i | p1_MemWrite_i.
- hit = valid[index] & (tag match).
- Both request bits high is illegal; it is treated as a write.
- Reset (rst_i=0, async):
  - state=IDLE; all valid and dirty bits cleared; data array contents don't-care.
  - mem_enable_o=0, mem_write_o=0, p1_stall_o=0, p1_data_o=0.
  - Reset mid-transfer aborts the transfer immediately; dirty data is lost.
- FSM states: IDLE, MISS, WRITEBACK, ALLOCATE, ALLOC_DONE.
- IDLE:
  - No req: p1_stall_o=0, p1_data_o=0.
  - req & hit: p1_stall_o=0.
    - Read: p1_data_o = selected word, combinational, same cycle.
    - Write: word updated and dirty set at the clock edge.
  - req & !hit: p1_stall_o=1 combinationally; next state MISS.
- MISS (1 cycle, stall=1):
  - Victim valid & dirty -> WRITEBACK.
  - Otherwise -> ALLOCATE.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1.
  - mem_addr_o = {victim tag, index, 5'b0}; mem_data_o = victim line.
  - Held until mem_ack_i=1 is sampled, then -> ALLOCATE.
- ALLOCATE:
  - mem_enable_o=1, mem_write_o=0, mem_addr_o = {req tag, index, 5'b0}.
  - On mem_ack_i=1: line <- mem_data_i, valid=1, dirty=0, tag updated; -> ALLOC_DONE.
- ALLOC_DONE (1 cycle, stall=1): -> IDLE, where the request now hits and completes normally (a write miss sets dirty at that point).
- mem_enable_o and mem_write_o decode from state only (glitch-free). They are 0 in IDLE, MISS and ALLOC_DONE.
- mem_ack_i is ignored outside WRITEBACK and ALLOCATE.
- mem_data_o and mem_addr_o are don't-care when mem_enable_o=0; drive 0.
- CPU holds p1 inputs stable while p1_stall_o=1. If req drops mid-miss, the fill still completes and the FSM returns to IDLE.
- Latency (memory acks on the L-th enabled cycle):
  - Hit: 0 stall cycles.
  - Clean miss: L+3 stall cycles.
  - Dirty miss: 2L+3 stall cycles.
- Simultaneous write hit and fill to the same line is impossible: writes occur only in IDLE.

Decomposition:
- Package dcache_pkg:
  - state enum (IDLE, MISS, WRITEBACK, ALLOCATE, ALLOC_DONE).
  - TAG_W, IDX_W, OFS_W, WORD_SEL_W constants.
  - Address-field extraction functions.
- Sub-module dcache_sram: tag array (valid/dirty/tag) and data array.
  - One combinational read port.
  - One write port, with either a full-line write or a single-word write with word select.
  - Async clear of valid/dirty.
- dcache_controller keeps the FSM and the hit/miss logic.

Test Plan (memory model L=10, memory word = address pattern):
- Reset, then read 0x0000_0040 -> p1_stall_o high 13 cycles; one request with mem_addr_o=0x40, mem_write_o=0; p1_data_o=0x40 when stall drops.
- Read 0x44 after the fill -> p1_stall_o=0 that cycle, p1_data_o=0x44, mem_enable_o stays 0.
- Write 0x48 = 0xDEADBEEF (hit) -> no stall, no memory traffic; a following read of 0x48 returns 0xDEADBEEF.
- Read 0x440 (index 2, new tag) -> write-back at 0x40 with mem_data_o[95:64]=0xDEADBEEF, then fill at 0x440; stall 23 cycles; data 0x440.
- Write miss 0x80 = 0x12345678 (clean victim) -> fill at 0x80 only, stall 13 cycles; a later read of 0x80 returns 0x12345678; a subsequent conflicting miss at 0x480 writes back line 0x80.
- Assert rst_i low during ALLOCATE -> mem_enable_o and p1_stall_o go 0 immediately without a clock; after release, a read of 0x44 misses again.
